multicycle_ctrl: RTL and testbench

- Control FSM for the multi-cycle RV32I core.
- Sequences the shared datapath (PC, IR, register file, ALU, immgen, single unified memory port) through FETCH/DECODE/EXEC/MEM/WB.
- Drives immgen's imm_sel with the IMM_* encodings from imm_types.vh.
- Arbitrates the one memory port between instruction fetch and load/store with a req/ready handshake.

---
 rtl/multicycle_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multi-cycle RV32I core (RST_WAIT/FETCH/DECODE/EXEC/MEM/WB).
// Latency: zero-wait CPI is ALU=4, load=5, store=4, branch/jump=3; first fetch RESET_WAIT cycles after reset release.
// Backpressure: FETCH and MEM hold mem_req/addr/we stable until mem_ready. MULTICYCLE_CTRL_EXC_EN adds an illegal-opcode TRAP.

`ifndef IMM_TYPE_WIDTH
`define IMM_TYPE_WIDTH 3
`endif
`ifndef IMM_I
`define IMM_I 3'd0
`endif
`ifndef IMM_S
`define IMM_S 3'd1
`endif
`ifndef IMM_B
`define IMM_B 3'd2
`endif
`ifndef IMM_U
`define IMM_U 3'd3
`endif
`ifndef IMM_J
`define IMM_J 3'd4
`endif

module multicycle_ctrl #(
  parameter int RESET_WAIT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                instr,
  input  logic                       br_taken,
  input  logic                       mem_ready,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic                       mem_addr_sel,
  output logic                       ir_we,
  output logic                       pc_we,
  output logic                       pc_src,
  output logic                       rf_we,
  output logic [1:0]                 wb_sel,
  output logic                       alu_a_sel,
  output logic                       alu_b_sel,
  output logic [1:0]                 alu_op,
  output logic [`IMM_TYPE_WIDTH-1:0] imm_sel,
  output logic                       instr_retired,
  output logic                       busy_mem
`ifdef MULTICYCLE_CTRL_EXC_EN
  ,
  output logic                       illegal_instr
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_RST_WAIT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
`ifdef MULTICYCLE_CTRL_EXC_EN
    ,
    S_TRAP
`endif
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic [6:0] opcode;
  logic [3:0] alu_cfg;
  logic [`IMM_TYPE_WIDTH-1:0] imm_dec;

  // Only the opcode field steers control; the rest of the IR feeds the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[31:7];
  assign opcode = instr[6:0];

`ifdef MULTICYCLE_CTRL_EXC_EN
  // RV32I opcodes this core executes; FENCE/SYSTEM are deliberately excluded.
  logic opc_legal;
  always_comb begin
    opc_legal = 1'b0;
    case (opcode)
      OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: opc_legal = 1'b1;
      default: opc_legal = 1'b0;
    endcase
  end
`endif

  // State sequencing and the post-reset idle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RST_WAIT;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        S_RST_WAIT: begin
          if (wait_cnt == 4'(RESET_WAIT - 1)) begin
            state    <= S_FETCH;
            wait_cnt <= 4'd0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_FETCH: if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
`ifdef MULTICYCLE_CTRL_EXC_EN
          if (!opc_legal) state <= S_TRAP;
          else            state <= S_EXEC;
`else
          state <= S_EXEC;
`endif
        end
        S_EXEC: begin
          case (opcode)
            OPC_LOAD, OPC_STORE:                    state <= S_MEM;
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC:  state <= S_WB;
            default:                                state <= S_FETCH;
          endcase
        end
        S_MEM: if (mem_ready) state <= (opcode == OPC_LOAD) ? S_WB : S_FETCH;
        S_WB: state <= S_FETCH;
`ifdef MULTICYCLE_CTRL_EXC_EN
        S_TRAP: state <= S_TRAP;
`endif
        default: state <= S_RST_WAIT;
      endcase
    end
  end

  // Immediate format by opcode; unknown opcodes fall back to I-type.
  always_comb begin
    imm_dec = `IMM_I;
    case (opcode)
      OPC_STORE:          imm_dec = `IMM_S;
      OPC_BRANCH:         imm_dec = `IMM_B;
      OPC_LUI, OPC_AUIPC: imm_dec = `IMM_U;
      OPC_JAL:            imm_dec = `IMM_J;
      default:            imm_dec = `IMM_I;
    endcase
  end

  // ALU operand/operation selection {a_sel, b_sel, op}, held through MEM and WB.
  always_comb begin
    alu_cfg = 4'b0000;
    case (opcode)
      OPC_OP:                        alu_cfg = 4'b0001;
      OPC_OPIMM:                     alu_cfg = 4'b0101;
      OPC_LOAD, OPC_STORE, OPC_JALR: alu_cfg = 4'b0100;
      OPC_BRANCH, OPC_JAL, OPC_AUIPC: alu_cfg = 4'b1100;
      default:                       alu_cfg = 4'b0000;
    endcase
  end

  // Strobes and selects decoded from state, opcode and the memory handshake.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_src        = 1'b0;
    rf_we         = 1'b0;
    wb_sel        = 2'd0;
    alu_a_sel     = 1'b0;
    alu_b_sel     = 1'b0;
    alu_op        = 2'd0;
    instr_retired = 1'b0;
    imm_sel       = `IMM_I;

    if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB) begin
      imm_sel = imm_dec;
    end
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      {alu_a_sel, alu_b_sel, alu_op} = alu_cfg;
    end

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_EXEC: begin
        case (opcode)
          OPC_BRANCH: begin
            pc_we         = 1'b1;
            pc_src        = br_taken;
            instr_retired = 1'b1;
          end
          OPC_JAL, OPC_JALR: begin
            pc_we         = 1'b1;
            pc_src        = 1'b1;
            rf_we         = 1'b1;
            wb_sel        = 2'd2;
            instr_retired = 1'b1;
          end
          OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC: begin
            pc_we = 1'b0;
          end
          default: begin
            // FENCE, SYSTEM and unknown opcodes retire as a NOP.
            pc_we         = 1'b1;
            instr_retired = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OPC_STORE);
        if (opcode == OPC_STORE && mem_ready) begin
          pc_we         = 1'b1;
          instr_retired = 1'b1;
        end
      end
      S_WB: begin
        rf_we         = 1'b1;
        pc_we         = 1'b1;
        instr_retired = 1'b1;
        if (opcode == OPC_LOAD)     wb_sel = 2'd1;
        else if (opcode == OPC_LUI) wb_sel = 2'd3;
        else                        wb_sel = 2'd0;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase

    busy_mem = mem_req & ~mem_ready;
  end

`ifdef MULTICYCLE_CTRL_EXC_EN
  assign illegal_instr = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl with RESET_WAIT=3.
// Acts as memory and IR: fetches load instr from a chosen word, mem_ready stalls are scripted per access.
// Per-instruction behaviour is compared against a transaction-level model of the instruction classes.

`ifndef IMM_TYPE_WIDTH
`define IMM_TYPE_WIDTH 3
`endif
`ifndef IMM_I
`define IMM_I 3'd0
`endif
`ifndef IMM_S
`define IMM_S 3'd1
`endif
`ifndef IMM_B
`define IMM_B 3'd2
`endif
`ifndef IMM_U
`define IMM_U 3'd3
`endif
`ifndef IMM_J
`define IMM_J 3'd4
`endif

module tb_multicycle_ctrl;
  localparam int RW = 3;
  localparam int II = int'(`IMM_I);
  localparam int IS = int'(`IMM_S);
  localparam int IB = int'(`IMM_B);
  localparam int IU = int'(`IMM_U);
  localparam int IJ = int'(`IMM_J);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic br_taken = 1'b0;
  logic mem_ready = 1'b1;
  logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, rf_we;
  logic [1:0] wb_sel, alu_op;
  logic alu_a_sel, alu_b_sel, instr_retired, busy_mem;
  logic [`IMM_TYPE_WIDTH-1:0] imm_sel;
`ifdef MULTICYCLE_CTRL_EXC_EN
  logic illegal_instr;
`endif

  multicycle_ctrl #(.RESET_WAIT(RW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op), .imm_sel(imm_sel),
    .instr_retired(instr_retired), .busy_mem(busy_mem)
`ifdef MULTICYCLE_CTRL_EXC_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Per-instruction summary: cycle count, rf writes, wb_sel at the rf write, store handshakes,
  // pc_src/imm_sel/{a,b,op} at retirement, cycles spent in fetch and data access (alu -1 = don't care).
  typedef struct {
    int cycles; int rf; int wbsel; int stores; int pcsrc; int imm; int fcyc; int mcyc; int alu;
  } exp_t;

  typedef struct {
    logic [31:0] word; int fw; int mw; logic bt; exp_t e;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int strobes();
    return int'({mem_req, ir_we, pc_we, rf_we, instr_retired});
  endfunction

  function automatic int selects();
    return int'({mem_we, mem_addr_sel, pc_src, wb_sel, alu_a_sel, alu_b_sel, alu_op});
  endfunction

  // Instruction-class reference: costs and effects straight from the ISA-level rules.
  function automatic exp_t model(input logic [31:0] w, input int fw, input int mw, input logic bt);
    exp_t e;
    e = '{default: 0};
    e.imm  = II;
    e.alu  = -1;
    e.fcyc = fw + 1;
    case (w[6:0])
      7'b0110011: begin e.cycles = 4; e.rf = 1; e.alu = 1; end
      7'b0010011: begin e.cycles = 4; e.rf = 1; e.alu = 5; end
      7'b0000011: begin e.cycles = 5 + mw; e.rf = 1; e.wbsel = 1; e.mcyc = mw + 1; e.alu = 4; end
      7'b0100011: begin e.cycles = 4 + mw; e.stores = 1; e.mcyc = mw + 1; e.imm = IS; e.alu = 4; end
      7'b1100011: begin e.cycles = 3; e.pcsrc = int'(bt); e.imm = IB; e.alu = 12; end
      7'b1101111: begin e.cycles = 3; e.rf = 1; e.wbsel = 2; e.pcsrc = 1; e.imm = IJ; e.alu = 12; end
      7'b1100111: begin e.cycles = 3; e.rf = 1; e.wbsel = 2; e.pcsrc = 1; e.alu = 4; end
      7'b0110111: begin e.cycles = 4; e.rf = 1; e.wbsel = 3; e.imm = IU; end
      7'b0010111: begin e.cycles = 4; e.rf = 1; e.imm = IU; e.alu = 12; end
      default:    begin e.cycles = 3; end
    endcase
    e.cycles += fw;
    return e;
  endfunction

  task automatic reset_to_fetch();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (RW) @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH (called at posedge+1) until retirement.
  task automatic run_instr(input logic [31:0] word, input int fw, input int mw, input logic bt,
                           output exp_t o, output int irw, output int pcw, output int rpw,
                           output int ok);
    int fcnt;
    int mcnt;
    bit load_ir;
    bit done;
    fcnt = fw; mcnt = mw; load_ir = 0; done = 0;
    o = '{default: 0};
    irw = 0; pcw = 0; rpw = 0;
    br_taken = bt;
    for (int c = 0; c < 60 && !done; c++) begin
      if (load_ir) begin instr = word; load_ir = 0; end
      if (mem_req) begin
        if (!mem_addr_sel) begin mem_ready = (fcnt == 0); if (fcnt > 0) fcnt--; end
        else begin mem_ready = (mcnt == 0); if (mcnt > 0) mcnt--; end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #3;
      o.cycles++;
      if (mem_req && !mem_addr_sel) o.fcyc++;
      if (mem_req && mem_addr_sel) o.mcyc++;
      if (mem_req && mem_we && mem_ready) o.stores++;
      if (ir_we) begin irw++; load_ir = 1; end
      if (pc_we) pcw++;
      if (rf_we) begin o.rf++; o.wbsel = int'(wb_sel); end
      if (instr_retired) begin
        done    = 1;
        o.pcsrc = int'(pc_src);
        o.imm   = int'(imm_sel);
        o.alu   = int'({alu_a_sel, alu_b_sel, alu_op});
        rpw     = int'(pc_we);
      end
      @(posedge clk); #1;
    end
    ok = int'(done);
  endtask

  task automatic compare(input string tag, input exp_t e, input exp_t o,
                         input int irw, input int pcw, input int rpw, input int ok);
    check({tag, " retired"}, ok, 1);
    check({tag, " cycles"}, o.cycles, e.cycles);
    check({tag, " rf_we count"}, o.rf, e.rf);
    check({tag, " wb_sel"}, o.wbsel, e.wbsel);
    check({tag, " stores"}, o.stores, e.stores);
    check({tag, " pc_src"}, o.pcsrc, e.pcsrc);
    check({tag, " imm_sel"}, o.imm, e.imm);
    check({tag, " fetch cycles"}, o.fcyc, e.fcyc);
    check({tag, " mem cycles"}, o.mcyc, e.mcyc);
    if (e.alu >= 0) check({tag, " alu sel"}, o.alu, e.alu);
    check({tag, " ir_we count"}, irw, 1);
    check({tag, " pc_we count"}, pcw, 1);
    check({tag, " pc_we at retire"}, rpw, 1);
    if (ok == 0) reset_to_fetch();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    logic [6:0] ops[$];
    exp_t o;
    int irw, pcw, rpw, ok;

    vecs[0] = '{32'h00500093, 0, 0, 1'b0, '{4, 1, 0, 0, 0, II, 1, 0, 5}};   // ADDI
    vecs[1] = '{32'h0040A103, 0, 2, 1'b0, '{7, 1, 1, 0, 0, II, 1, 3, 4}};   // LW, 2 wait
    vecs[2] = '{32'h0020A223, 0, 0, 1'b0, '{4, 0, 0, 1, 0, IS, 1, 1, 4}};   // SW
    vecs[3] = '{32'h00208463, 0, 0, 1'b1, '{3, 0, 0, 0, 1, IB, 1, 0, 12}};  // BEQ taken
    vecs[4] = '{32'h00208463, 0, 0, 1'b0, '{3, 0, 0, 0, 0, IB, 1, 0, 12}};  // BEQ not taken
    vecs[5] = '{32'h008000EF, 0, 0, 1'b0, '{3, 1, 2, 0, 1, IJ, 1, 0, 12}};  // JAL
    vecs[6] = '{32'h002081B3, 2, 0, 1'b0, '{6, 1, 0, 0, 0, II, 3, 0, 1}};   // ADD, slow fetch
    vecs[7] = '{32'h123450B7, 0, 0, 1'b0, '{4, 1, 3, 0, 0, IU, 1, 0, -1}};  // LUI
    vecs[8] = '{32'h000080E7, 0, 0, 1'b0, '{3, 1, 2, 0, 1, II, 1, 0, 4}};   // JALR
    vecs[9] = '{32'h0000007F, 0, 0, 1'b0, '{3, 0, 0, 0, 0, II, 1, 0, -1}};  // unknown -> NOP

    // Reset state.
    #3;
    check("reset strobes", strobes(), 0);
    check("reset selects", selects(), 0);
    check("reset imm_sel", int'(imm_sel), II);
    check("reset busy_mem", int'(busy_mem), 0);
`ifdef MULTICYCLE_CTRL_EXC_EN
    check("reset illegal_instr", int'(illegal_instr), 0);
`endif

    // RESET_WAIT idle cycles, then fetch on the following cycle.
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= RW; k++) begin
      #3;
      check($sformatf("wait cycle %0d strobes", k), strobes(), 0);
      @(posedge clk); #1;
    end
    #3;
    check("first fetch mem_req", int'(mem_req), 1);
    check("first fetch addr/we", int'({mem_addr_sel, mem_we}), 0);
    check("first fetch ir_we", int'(ir_we), 1);
    mem_ready = 1'b0;
    #2;
    check("fetch stall ir_we", int'(ir_we), 0);
    check("fetch stall busy_mem", int'(busy_mem), 1);
    @(posedge clk); #1;
    check("fetch held mem_req", int'(mem_req), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort mem_req", int'(mem_req), 0);
    check("abort strobes", strobes(), 0);
    reset_to_fetch();

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
`ifdef MULTICYCLE_CTRL_EXC_EN
      if (vecs[i].word[6:0] == 7'h7F) continue;
`endif
      run_instr(vecs[i].word, vecs[i].fw, vecs[i].mw, vecs[i].bt, o, irw, pcw, rpw, ok);
      compare($sformatf("vec%0d", i), vecs[i].e, o, irw, pcw, rpw, ok);
    end

    // Random instruction stream with random memory stalls.
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
`ifndef MULTICYCLE_CTRL_EXC_EN
    ops.push_back(7'b0001111);
    ops.push_back(7'b1110011);
    ops.push_back(7'b1111111);
`endif
    for (int n = 0; n < 40; n++) begin
      logic [31:0] r;
      logic [31:0] w;
      int fw, mw;
      logic bt;
      r  = $urandom();
      w  = {r[31:7], ops[$urandom_range(0, ops.size() - 1)]};
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      bt = 1'($urandom_range(0, 1));
      run_instr(w, fw, mw, bt, o, irw, pcw, rpw, ok);
      compare($sformatf("rnd%0d op=%07b", n, w[6:0]), model(w, fw, mw, bt), o, irw, pcw, rpw, ok);
    end

`ifdef MULTICYCLE_CTRL_EXC_EN
    // Illegal opcode: trap after DECODE, no further memory traffic until reset.
    mem_ready = 1'b1;
    #3;
    check("trap fetch ir_we", int'(ir_we), 1);
    @(posedge clk); #1;
    instr = 32'h0000007F;
    #3;
    check("trap decode illegal", int'(illegal_instr), 0);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #3;
      check($sformatf("trap cycle %0d illegal", k), int'(illegal_instr), 1);
      check($sformatf("trap cycle %0d strobes", k), strobes(), 0);
      @(posedge clk); #1;
    end
    reset_to_fetch();
    #3;
    check("after trap reset illegal", int'(illegal_instr), 0);
    check("after trap reset mem_req", int'(mem_req), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
